// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 16;

    typedef logic [SEL_W-1:0] ch_sel_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single demux output channel.
// Latency: a loaded beat is visible immediately after the loading edge.
// Backpressure: holds its beat until take; a load on the same edge as take replaces it.
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             take,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (take) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1_4_stream.sv
// Registered 1-to-4 stream demux; optional per-channel transfer counters under DEMUX_CNT_EN.
// Latency: one edge from input accept to out_valid/out_data.
// Backpressure: in_ready stalls only while in_sel addresses a full, non-draining channel.
module demux_1_4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [NUM_CH*WIDTH-1:0]   out_data,
    output logic [NUM_CH-1:0]         out_valid,
    input  logic [NUM_CH-1:0]         out_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [NUM_CH*CNT_W-1:0]   cnt
`endif
);

    ch_sel_t           sel;
    logic              in_xfer;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] v;

    assign sel       = ch_sel_t'(in_sel);
    // A full slot still accepts when its consumer drains it on the same edge.
    assign in_ready  = ~v[sel] | out_ready[sel];
    assign in_xfer   = in_valid & in_ready;
    assign out_valid = v;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        assign load[n] = in_xfer && (sel == ch_sel_t'(n));

        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[n]),
            .load_data (in_data),
            .take      (out_ready[n]),
            .valid     (v[n]),
            .data      (out_data[n*WIDTH +: WIDTH])
        );
    end

`ifdef DEMUX_CNT_EN
    for (genvar n = 0; n < NUM_CH; n++) begin : g_cnt
        logic [CNT_W-1:0] c;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                c <= '0;
            end else if (load[n]) begin
                c <= c + CNT_W'(1);
            end
        end

        assign cnt[n*CNT_W +: CNT_W] = c;
    end
`endif

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Directed table-driven bench for demux_1_4_stream plus hand-written corner sequences.
module tb_demux_1_4_stream;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
`ifdef DEMUX_CNT_EN
    logic [63:0] cnt;
`endif

    int nvec = 0;
    int nerr = 0;

    demux_1_4_stream #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX_CNT_EN
        ,
        .cnt       (cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        valid;
        logic [1:0]  sel;
        logic [7:0]  data;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
        logic [31:0] exp_od;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] taken;
        logic [7:0] bdat;
        logic [1:0] bsel;

        // valid sel data ordy | rdy ov od
        vecs[0] = '{1'b1, 2'd0, 8'hA0, 4'b0000, 1'b1, 4'b0001, 32'h000000A0};
        vecs[1] = '{1'b1, 2'd1, 8'hA1, 4'b0000, 1'b1, 4'b0011, 32'h0000A1A0};
        vecs[2] = '{1'b1, 2'd2, 8'hA2, 4'b0000, 1'b1, 4'b0111, 32'h00A2A1A0};
        vecs[3] = '{1'b1, 2'd3, 8'hA3, 4'b0000, 1'b1, 4'b1111, 32'hA3A2A1A0};
        vecs[4] = '{1'b1, 2'd2, 8'hB0, 4'b0000, 1'b0, 4'b1111, 32'hA3A2A1A0};
        vecs[5] = '{1'b1, 2'd2, 8'hB0, 4'b0100, 1'b1, 4'b1111, 32'hA3B0A1A0};
        vecs[6] = '{1'b0, 2'd0, 8'h00, 4'b0001, 1'b1, 4'b1110, 32'hA3B0A100};
        vecs[7] = '{1'b1, 2'd0, 8'hC0, 4'b0000, 1'b1, 4'b1111, 32'hA3B0A1C0};
        vecs[8] = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h00000000};

        rst_n = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 4'b0000);
        #12;
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        chk("reset_out_data", 64'(out_data), 64'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].valid, vecs[i].sel, vecs[i].data, vecs[i].ordy);
            #1;
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_rdy));
            tick();
            chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
            for (int n = 0; n < 4; n++)
                if (vecs[i].exp_ov[n])
                    chk($sformatf("vec%0d_data%0d", i, n), 64'(out_data[n*8 +: 8]),
                        64'(vecs[i].exp_od[n*8 +: 8]));
        end

        // Asynchronous reset with all four slots full.
        for (int n = 0; n < 4; n++) begin
            drive(1'b1, 2'(n), 8'h40 + 8'(n), 4'b0000);
            tick();
        end
        chk("prereset_full", 64'(out_valid), 64'hF);
        drive(1'b0, 2'd0, 8'h00, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'h0);
        chk("midreset_out_data", 64'(out_data), 64'h0);
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            chk($sformatf("midreset_in_ready_sel%0d", s), 64'(in_ready), 64'h1);
        end
        rst_n = 1'b1;
        tick();

        // Channel 1 stalled while channels 0 and 3 stream.
        drive(1'b1, 2'd1, 8'h5A, 4'b0000);
        tick();
        for (int i = 0; i < 20; i++) begin
            bsel = (i % 2 == 0) ? 2'd0 : 2'd3;
            bdat = 8'h80 + 8'(i);
            drive(1'b1, bsel, bdat, 4'b1001);
            #1;
            chk($sformatf("iso%0d_in_ready", i), 64'(in_ready), 64'h1);
            tick();
            chk($sformatf("iso%0d_valid", i), 64'(out_valid[bsel]), 64'h1);
            chk($sformatf("iso%0d_data", i), 64'(out_data[bsel*8 +: 8]), 64'(bdat));
            chk($sformatf("iso%0d_ch1_valid", i), 64'(out_valid[1]), 64'h1);
            chk($sformatf("iso%0d_ch1_data", i), 64'(out_data[15:8]), 64'h5A);
        end
        drive(1'b1, 2'd1, 8'h00, 4'b0000);
        #1;
        chk("iso_ch1_blocks", 64'(in_ready), 64'h0);

        // Back-to-back beats into channel 2 with its consumer always ready.
        for (int i = 0; i < 16; i++) begin
            bdat = 8'hD0 + 8'(i);
            drive(1'b1, 2'd2, bdat, 4'b0100);
            #1;
            chk($sformatf("thru%0d_in_ready", i), 64'(in_ready), 64'h1);
            tick();
            chk($sformatf("thru%0d_valid", i), 64'(out_valid[2]), 64'h1);
            chk($sformatf("thru%0d_data", i), 64'(out_data[23:16]), 64'(bdat));
        end

        // Replace-on-take on channel 0.
        drive(1'b0, 2'd0, 8'h00, 4'b1001);
        tick();
        drive(1'b1, 2'd0, 8'h11, 4'b0000);
        tick();
        drive(1'b1, 2'd0, 8'h22, 4'b0001);
        #1;
        chk("rot_in_ready", 64'(in_ready), 64'h1);
        taken = out_data[7:0];
        chk("rot_first_take", 64'(taken), 64'h11);
        tick();
        chk("rot_valid", 64'(out_valid[0]), 64'h1);
        chk("rot_data", 64'(out_data[7:0]), 64'h22);
        drive(1'b0, 2'd0, 8'h00, 4'b0001);
        #1;
        taken = out_data[7:0];
        chk("rot_second_take", 64'(taken), 64'h22);
        tick();
        chk("rot_drained", 64'(out_valid[0]), 64'h0);

`ifdef DEMUX_CNT_EN
        drive(1'b0, 2'd0, 8'h00, 4'b0000);
        #1;
        rst_n = 1'b0;
        #1;
        chk("cnt_reset", cnt, 64'h0);
        rst_n = 1'b1;
        tick();
        drive(1'b1, 2'd3, 8'h77, 4'b1000);
        repeat (65537) @(posedge clk);
        #1;
        drive(1'b0, 2'd0, 8'h00, 4'b0000);
        chk("cnt_ch3_wrap", 64'(cnt[63:48]), 64'h1);
        chk("cnt_others", 64'(cnt[47:0]), 64'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/demux_1_4_stream.md
# demux_1_4_stream

Registered 1-to-4 stream demultiplexer: the distribution-side counterpart of the team's 4:1 mux. It accepts a single valid/ready input stream carrying a 2-bit channel select and routes each beat to one of four output channels. Each output channel has its own one-entry holding register, so a stalled channel never drops data and never corrupts another channel. The block sits between a shared producer and four independent consumers.

## Interface
- WIDTH, 8, data width of one beat in bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  input beat payload.
- in_sel  input  2  destination channel (0..3) of the current beat.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept the beat addressed by in_sel this cycle.
- out_data  output  4*WIDTH  channel n payload in bits [n*WIDTH +: WIDTH].
- out_valid  output  4  bit n: channel n holds a beat.
- out_ready  input  4  bit n: consumer n takes the beat this cycle.
- cnt  output  64  per-channel transfer counters, channel n in bits [n*16 +: 16]. Present only with DEMUX_CNT_EN.

## Operation
- Slot state per channel n: valid flag v[n] and data register d[n]. out_valid[n] = v[n]; out_data slice n = d[n].
- Input transfer: in_valid & in_ready on a rising clk edge.
- Output transfer on channel n: v[n] & out_ready[n] on a rising clk edge.
- in_ready = ~v[in_sel] | out_ready[in_sel]. This is combinational from in_sel and out_ready. It does not depend on in_valid.
- On an input transfer: d[in_sel] <= in_data and v[in_sel] <= 1.
- On an output transfer on channel n with no input transfer to n: v[n] <= 0. d[n] is held, and its value is don't-care.
- Simultaneous output and input on the same channel: the new beat replaces the old one, and v stays 1. This gives full throughput with no bubble.
- Output channels are independent. A stalled channel blocks the input only while in_sel addresses that channel, which is head-of-line blocking at the input.
- Beat order within each channel is preserved. No beat is dropped or duplicated.
- in_sel is sampled only on an input transfer. When in_valid is 0, in_data and in_sel are don't-care.

## Timing
- Reset (rst_n low, asynchronous): v = 0000, out_valid = 0, d = 0, so out_data = 0. All counters are 0. in_ready = 1 for every in_sel, because it follows combinationally from v = 0.
- Latency: a beat accepted at edge k is visible on out_valid/out_data immediately after edge k.
- Throughput: 1 beat per cycle into any channel whose consumer holds out_ready = 1.
- Reset asserted mid-operation: all held beats are discarded immediately. Deassertion is synchronised externally; the block has no reset synchroniser.
- Rule for the producer: in_data and in_sel must be held stable while in_valid = 1 and in_ready = 0. The block does not check this rule.

## Configuration
- DEMUX_CNT_EN defined: the cnt port exists. Channel n's 16-bit counter increments by 1 on each input transfer to channel n and wraps from 16'hFFFF to 0. Counters are reset by rst_n only.
- DEMUX_CNT_EN undefined: the cnt port and the counter logic are absent. Routing behaviour is identical in both builds.

## Structure
- Package demux_pkg holds:
  - NUM_CH = 4, SEL_W = 2, CNT_W = 16.
  - typedef ch_sel_t as logic [SEL_W-1:0].
- Sub-module demux_slot: the one-entry holding register with ports clk, rst_n, load, load_data, take, valid, data. The top level instantiates it NUM_CH times.
- The top level contains the in_sel decode, the in_ready mux and the optional counters.

## Test plan
- Reset: assert rst_n = 0 mid-stream with v = 1111. Required response: out_valid = 0000, out_data = 0, and in_ready = 1 for every in_sel.
- Basic routing: send 8'hA0..8'hA3 with in_sel = 0..3 and out_ready = 0000. Required response: out_valid = 1111 and out_data = {A3,A2,A1,A0}. A further beat to channel 2 then sees in_ready = 0.
- Backpressure isolation: hold out_ready[1] = 0 with channel 1 full, then send 20 beats alternately to channels 0 and 3 with out_ready = 1001. Required response: all 20 beats are delivered in order, and channel 1 data is unchanged.
- Full throughput: 16 back-to-back beats to channel 2 with out_ready[2] = 1. Required response: in_ready stays 1 and out_data[2] shows each beat in the cycle after it is accepted, with no gaps.
- Replace-on-take: with v[0] = 1 holding 8'h11, apply out_ready[0] = 1 and an input of 8'h22 to channel 0 in the same cycle. Required response: next cycle v[0] = 1 and data = 8'h22. The consumer has received 8'h11 exactly once.
- DEMUX_CNT_EN build: 65537 transfers to channel 3. Required response: cnt[63:48] = 1, and the other channel counters are unchanged.
